// File: rtl/saturador_iv.sv
// rtl/saturador_iv.sv - IEEE-754 single current/voltage range limiter with start/ack handshake
//
// Clamps a latched current sample I into [I_MIN, I_MAX] and a latched voltage
// sample V into [V_MIN, V_MAX]. Both channels are handled in one transaction.
//
// Ports:
//   CLK       rising-edge clock
//   reset     synchronous, active-high reset
//   start_e   transaction request (level); accepted only from IDLE
//   I, V      IEEE-754 single samples, latched when a request is accepted
//   ack_e     high while in DONE (registered Moore output)
//   result_i  limited current, held until the next compare or reset
//   result_v  limited voltage, held until the next compare or reset
//   sat_i     result_i was forced to a limit
//   sat_v     result_v was forced to a limit

module saturador_iv #(
  parameter logic [31:0] I_MAX = 32'h41200000,
  parameter logic [31:0] I_MIN = 32'hC1200000,
  parameter logic [31:0] V_MAX = 32'h43480000,
  parameter logic [31:0] V_MIN = 32'h00000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start_e,
  input  logic [31:0] I,
  input  logic [31:0] V,
  output logic        ack_e,
  output logic [31:0] result_i,
  output logic [31:0] result_v,
  output logic        sat_i,
  output logic        sat_v
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] i_lat;
  logic [31:0] v_lat;

  // Maps a float onto an unsigned key whose ordering matches numeric order.
  // -0.0 is folded onto +0.0 first so the two zeros compare equal.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    logic [31:0] xn;
    xn = (x == 32'h80000000) ? 32'h00000000 : x;
    return xn[31] ? ~xn : {1'b1, xn[30:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Returns {sat, result}. In-range inputs pass through bit-exact, so a
  // -0.0 input leaves as -0.0 even though it was compared as +0.0.
  function automatic logic [32:0] limit(input logic [31:0] x,
                                        input logic [31:0] mx,
                                        input logic [31:0] mn);
    logic [32:0] r;
    if (is_nan(x))
      r = {1'b1, mn};
    else if (order_key(x) > order_key(mx))
      r = {1'b1, mx};
    else if (order_key(x) < order_key(mn))
      r = {1'b1, mn};
    else
      r = {1'b0, x};
    return r;
  endfunction

  logic [32:0] lim_i;
  logic [32:0] lim_v;

  assign lim_i = limit(i_lat, I_MAX, I_MIN);
  assign lim_v = limit(v_lat, V_MAX, V_MIN);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      ack_e    <= 1'b0;
      i_lat    <= 32'h0;
      v_lat    <= 32'h0;
      result_i <= 32'h0;
      result_v <= 32'h0;
      sat_i    <= 1'b0;
      sat_v    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_e <= 1'b0;
          if (start_e) begin
            i_lat <= I;
            v_lat <= V;
            state <= CMP;
          end
        end
        CMP: begin
          result_i <= lim_i[31:0];
          sat_i    <= lim_i[32];
          result_v <= lim_v[31:0];
          sat_v    <= lim_v[32];
          ack_e    <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // Leaving DONE needs start_e low, so no request can be taken on
          // this edge; a new one is only seen from IDLE on the next edge.
          if (!start_e) begin
            ack_e <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack_e <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saturador_iv.sv
// tb/tb_saturador_iv.sv - directed self-checking bench for saturador_iv

module tb_saturador_iv;

  logic        CLK;
  logic        reset;
  logic        start_e;
  logic [31:0] I;
  logic [31:0] V;
  logic        ack_e;
  logic [31:0] result_i;
  logic [31:0] result_v;
  logic        sat_i;
  logic        sat_v;

  int checks;
  int errors;

  saturador_iv dut (
    .CLK      (CLK),
    .reset    (reset),
    .start_e  (start_e),
    .I        (I),
    .V        (V),
    .ack_e    (ack_e),
    .result_i (result_i),
    .result_v (result_v),
    .sat_i    (sat_i),
    .sat_v    (sat_v)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive a request at a falling edge; the following rising edge samples it.
  task automatic issue(input logic [31:0] i_val, input logic [31:0] v_val);
    @(negedge CLK);
    start_e = 1'b1;
    I       = i_val;
    V       = v_val;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    start_e = 1'b1;
    I       = 32'h40A00000;
    V       = 32'h42C80000;
    repeat (3) @(negedge CLK);
    checks++;
    if (ack_e !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack_e); end
    checks++;
    if (result_i !== 32'h0 || result_v !== 32'h0) begin
      errors++; $display("FAIL reset_results got %h/%h exp 00000000/00000000", result_i, result_v);
    end
    checks++;
    if ({sat_i, sat_v} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b exp 00", sat_i, sat_v); end
    // First edge with reset low and start_e high must accept.
    reset = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b1) begin errors++; $display("FAIL first_accept_ack got %b exp 1", ack_e); end
    start_e = 1'b0;
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b0) begin errors++; $display("FAIL first_release_ack got %b exp 0", ack_e); end
  endtask

  task automatic test_pass;
    issue(32'h40A00000, 32'h42C80000);
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b0) begin errors++; $display("FAIL pass_latency1 got %b exp 0", ack_e); end
    // Input changes while in CMP must not leak into this transaction.
    I = 32'h7FC00000;
    V = 32'h41A00000;
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b1) begin errors++; $display("FAIL pass_latency2 got %b exp 1", ack_e); end
    checks++;
    if (result_i !== 32'h40A00000) begin errors++; $display("FAIL pass_result_i got %h exp 40a00000", result_i); end
    checks++;
    if (result_v !== 32'h42C80000) begin errors++; $display("FAIL pass_result_v got %h exp 42c80000", result_v); end
    checks++;
    if ({sat_i, sat_v} !== 2'b00) begin errors++; $display("FAIL pass_flags got %b%b exp 00", sat_i, sat_v); end
    start_e = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (ack_e !== 1'b0) begin errors++; $display("FAIL pass_idle_ack got %b exp 0", ack_e); end
    checks++;
    if (result_i !== 32'h40A00000 || result_v !== 32'h42C80000 || {sat_i, sat_v} !== 2'b00) begin
      errors++; $display("FAIL pass_hold got %h/%h/%b%b exp 40a00000/42c80000/00", result_i, result_v, sat_i, sat_v);
    end
  endtask

  task automatic test_saturate;
    issue(32'h41A00000, 32'hC0000000);
    repeat (2) @(negedge CLK);
    checks++;
    if (result_i !== 32'h41200000 || sat_i !== 1'b1) begin
      errors++; $display("FAIL sat_high_i got %h/%b exp 41200000/1", result_i, sat_i);
    end
    checks++;
    if (result_v !== 32'h00000000 || sat_v !== 1'b1) begin
      errors++; $display("FAIL sat_low_v got %h/%b exp 00000000/1", result_v, sat_v);
    end
    start_e = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_nan_inf;
    issue(32'h7FC00000, 32'h7F800000);
    repeat (2) @(negedge CLK);
    checks++;
    if (result_i !== 32'hC1200000 || sat_i !== 1'b1) begin
      errors++; $display("FAIL nan_i got %h/%b exp c1200000/1", result_i, sat_i);
    end
    checks++;
    if (result_v !== 32'h43480000 || sat_v !== 1'b1) begin
      errors++; $display("FAIL pinf_v got %h/%b exp 43480000/1", result_v, sat_v);
    end
    start_e = 1'b0;
    @(negedge CLK);
    // -Inf on current clamps low; V exactly at V_MAX passes.
    issue(32'hFF800000, 32'h43480000);
    repeat (2) @(negedge CLK);
    checks++;
    if (result_i !== 32'hC1200000 || sat_i !== 1'b1) begin
      errors++; $display("FAIL ninf_i got %h/%b exp c1200000/1", result_i, sat_i);
    end
    checks++;
    if (result_v !== 32'h43480000 || sat_v !== 1'b0) begin
      errors++; $display("FAIL vmax_exact got %h/%b exp 43480000/0", result_v, sat_v);
    end
    start_e = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_boundary;
    issue(32'hC1200000, 32'h80000000);
    repeat (2) @(negedge CLK);
    checks++;
    if (result_i !== 32'hC1200000 || sat_i !== 1'b0) begin
      errors++; $display("FAIL imin_exact got %h/%b exp c1200000/0", result_i, sat_i);
    end
    checks++;
    if (result_v !== 32'h80000000 || sat_v !== 1'b0) begin
      errors++; $display("FAIL neg_zero_v got %h/%b exp 80000000/0", result_v, sat_v);
    end
    start_e = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    issue(32'h3F800000, 32'hC2C80000);
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ack_e !== 1'b1) begin errors++; $display("FAIL hold_ack[%0d] got %b exp 1", k, ack_e); end
      @(negedge CLK);
    end
    checks++;
    if (result_i !== 32'h3F800000 || sat_i !== 1'b0 || result_v !== 32'h00000000 || sat_v !== 1'b1) begin
      errors++; $display("FAIL hold_results got %h/%b %h/%b exp 3f800000/0 00000000/1", result_i, sat_i, result_v, sat_v);
    end
    start_e = 1'b0;
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b0) begin errors++; $display("FAIL release_ack got %b exp 0", ack_e); end
    // Re-raise right after leaving DONE: accepted on the next edge.
    start_e = 1'b1;
    I       = 32'hC0A00000;
    V       = 32'h43C80000;
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b0) begin errors++; $display("FAIL reraise_cmp_ack got %b exp 0", ack_e); end
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b1) begin errors++; $display("FAIL reraise_done_ack got %b exp 1", ack_e); end
    checks++;
    if (result_i !== 32'hC0A00000 || sat_i !== 1'b0 || result_v !== 32'h43480000 || sat_v !== 1'b1) begin
      errors++; $display("FAIL reraise_results got %h/%b %h/%b exp c0a00000/0 43480000/1", result_i, sat_i, result_v, sat_v);
    end
    start_e = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    issue(32'h41A00000, 32'hC0000000);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checks++;
    if (ack_e !== 1'b0) begin errors++; $display("FAIL midreset_ack got %b exp 0", ack_e); end
    checks++;
    if (result_i !== 32'h0 || result_v !== 32'h0 || {sat_i, sat_v} !== 2'b00) begin
      errors++; $display("FAIL midreset_state got %h/%h/%b%b exp 00000000/00000000/00", result_i, result_v, sat_i, sat_v);
    end
    reset   = 1'b0;
    start_e = 1'b0;
    @(negedge CLK);
    issue(32'hBF800000, 32'h42480000);
    repeat (2) @(negedge CLK);
    checks++;
    if (ack_e !== 1'b1 || result_i !== 32'hBF800000 || result_v !== 32'h42480000 || {sat_i, sat_v} !== 2'b00) begin
      errors++; $display("FAIL after_reset got %b %h/%h/%b%b exp 1 bf800000/42480000/00", ack_e, result_i, result_v, sat_i, sat_v);
    end
    start_e = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start_e = 1'b0;
    I       = 32'h0;
    V       = 32'h0;
    test_reset;
    test_pass;
    test_saturate;
    test_nan_inf;
    test_boundary;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/saturador_iv.md
SATURADOR_IV -- requirements
Module: saturador_iv

Interface
REQ-001 The block SHALL have parameter I_MAX, default 32'h41200000 (+10.0), which is the IEEE-754 single upper limit for current.
REQ-002 The block SHALL have parameter I_MIN, default 32'hC1200000 (-10.0), which is the lower limit for current.
REQ-003 The block SHALL have parameter V_MAX, default 32'h43480000 (+200.0), which is the upper limit for voltage.
REQ-004 The block SHALL have parameter V_MIN, default 32'h00000000 (+0.0), which is the lower limit for voltage; each MIN SHALL be no greater than its MAX.
REQ-005 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port start_e, input, 1 bit: transaction request from the flow-control FSM; level signal.
REQ-008 Port I, input, 32 bits: IEEE-754 single current sample from the normalizer.
REQ-009 Port V, input, 32 bits: IEEE-754 single voltage sample from the normalizer.
REQ-010 Port ack_e, output, 1 bit: transaction complete; level signal.
REQ-011 Port result_i, output, 32 bits: limited current.
REQ-012 Port result_v, output, 32 bits: limited voltage.
REQ-013 Port sat_i, output, 1 bit: set when result_i was forced to a limit.
REQ-014 Port sat_v, output, 1 bit: set when result_v was forced to a limit.

Function
REQ-015 The FSM SHALL have three states: IDLE, CMP and DONE; ack_e SHALL be 1 only in DONE (Moore, registered).
REQ-016 In IDLE with start_e=1 sampled at edge n, the block SHALL latch I and V and move to CMP.
REQ-017 At edge n+1 the block SHALL go CMP->DONE and update result_i, result_v, sat_i and sat_v in the same edge; ack_e SHALL therefore be high after edge n+1 (latency: 2 edges).
REQ-018 In DONE, ack_e SHALL hold while start_e=1; when start_e=0 is sampled, the block SHALL return to IDLE and drop ack_e.
REQ-019 A new request SHALL be accepted only from IDLE; start_e=1 on the edge that leaves DONE SHALL be ignored.
REQ-020 I and V changes while in CMP/DONE SHALL NOT affect the current transaction.
REQ-021 Results and flags SHALL hold between transactions until the next CMP edge or reset.
REQ-022 Comparison: -0.0 (32'h80000000) SHALL be normalized to +0.0, then mapped to an ordered key: sign=0 -> {1'b1, x[30:0]}; sign=1 -> ~x; compared as unsigned 32-bit.
REQ-023 If key(x) > key(MAX), the result SHALL be MAX and sat=1.
REQ-024 If key(x) < key(MIN), the result SHALL be MIN and sat=1.
REQ-025 Otherwise the result SHALL be the original input bits, unmodified (including -0.0), and sat=0.
REQ-026 NaN input (exponent 8'hFF, mantissa != 0) SHALL yield MIN and sat=1; +/-Inf SHALL follow the normal compare.
REQ-027 The I and V channels SHALL be independent and SHALL always complete together in one transaction.

Reset
REQ-028 reset=1 at any edge SHALL force IDLE, ack_e=0, result_i=result_v=32'h0 and sat_i=sat_v=0; it overrides start_e and aborts any transaction.
REQ-029 The first request SHALL be accepted on the first edge with reset=0 and start_e=1.

Verification
REQ-030 I=32'h40A00000 (5.0), V=32'h42C80000 (100.0), start_e pulse held -> ack_e high 2 edges later; result_i=40A00000, result_v=42C80000, sat_i=sat_v=0.
REQ-031 I=32'h41A00000 (20.0), V=32'hC0000000 (-2.0) -> result_i=41200000, sat_i=1; result_v=00000000, sat_v=1.
REQ-032 I=32'h7FC00000 (NaN), V=32'h7F800000 (+Inf) -> result_i=C1200000, sat_i=1; result_v=43480000, sat_v=1.
REQ-033 V=32'h80000000 (-0.0) -> result_v=80000000, sat_v=0; I=32'hC1200000 exactly -> passes, sat_i=0.
REQ-034 Hold start_e high 5 cycles after ack, then drop it -> ack_e stays high until the edge sampling start_e=0, then returns to IDLE; start_e re-raised on that same edge is ignored and accepted one edge later.
REQ-035 Assert reset during CMP -> next edge gives ack_e=0, results=0, flags=0; a later start still completes normally.
